uart_rx_os: RTL
===============

# uart_rx_os

Parametrised, oversampling UART receiver for the 16550-compatible serial path. It synchronises the asynchronous `rx` pin and validates the start bit. It then deserialises 5–8 data bits, checks optional parity and the first stop bit, and delivers one frame per `push` pulse with error flags. It sits between the baud generator (`baud_pulse`) and the RX FIFO. Compared with the previous receiver it adds:
- a configurable oversampling ratio;
- a metastability synchroniser;
- per-frame configuration latching;
- real break detection, with a wait for line release after a break;
- optional majority-vote sampling.

## Interface
- `OSR`, 16: baud_pulses per bit. Even, ≥ 8.
- `SYNC_STAGES`, 2: synchroniser flops on `rx`. ≥ 2.
- `clk` input 1: system clock. All logic is on the rising edge.
- `rst` input 1: reset, **asynchronous, active-high**.
- `baud_pulse` input 1: one-`clk` enable at OSR × baud rate.
- `rx` input 1: serial line, asynchronous. Idle level is 1.
- `pen` input 1: parity enable.
- `eps` input 1: even parity select.
- `sticky_parity` input 1: stick parity.
- `wls` input 2: word length. 00/01/10/11 = 5/6/7/8 bits.
- `push` output 1: one-cycle pulse; frame result valid.
- `dout` output 8: received word, right-justified, unused MSBs 0.
- `pe` output 1: parity error.
- `fe` output 1: framing error.
- `bi` output 1: break indicator.
- `busy` output 1: high whenever state ≠ IDLE.

## Operation
- **Synchroniser:** `rx` passes through SYNC_STAGES flops, which reset to 1. All decisions use the synchronised value `rx_s`.
- **Tick counter:** width $clog2(OSR). It advances on every `baud_pulse`. Each bit spans ticks 0..OSR-1.
- **Sample point:** S = OSR/2. The decision tick D is S, or S+1 when majority voting is compiled in (see Configuration).
- **States:** IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
- **IDLE:** on a `baud_pulse` with `rx_s` = 0, go to START. That pulse is tick 0.
- **START:** at D, evaluate the sample.
  - Sample = 1: false start, return to IDLE. No `push`.
  - Sample = 0: latch `wls`, `pen`, `eps` and `sticky_parity` for the whole frame.
  - At tick OSR-1, go to DATA with bit count N-1, where N = wls + 5.
- **DATA:**
  - At D, shift the sample in LSB-first into position N-1 of the shift register.
  - At tick OSR-1: if the count is 0, go to PARITY (when latched `pen` = 1) or STOP. Otherwise decrement the count.
- **PARITY:** at D, compute the parity error from {sticky_parity, eps}:
  - 00 (odd): error if XOR(data, p) = 0.
  - 01 (even): error if XOR(data, p) = 1.
  - 10: error if p = 0.
  - 11: error if p = 1.
- **STOP:** at D, sample the first stop bit only; a second stop bit is not checked.
  - fe = ~sample.
  - bi = 1 when all data bits, the parity bit (if enabled) and the stop bit are 0. Break also sets fe = 1.
  - After the decision, go to IDLE if sample = 1, or to BRK_WAIT if sample = 0.
- **BRK_WAIT:** on a `baud_pulse` with `rx_s` = 1, go to IDLE. A line held low never produces a second `push`.
- **`pe` with parity disabled:** `pe` = 0 for frames received with `pen` = 0.
- **Output registers:**
  - `dout`, `pe`, `fe` and `bi` load in the same cycle as `push` and hold until the next `push`.
  - `push` is never asserted outside the cycle following the STOP decision pulse.
- **Back-to-back frames:** returning to IDLE at mid-stop allows a start edge as early as tick D+1 of the stop bit.
- **Configuration inputs:** changes to `wls`, `pen`, `eps` or `sticky_parity` during a frame have no effect until the next START validation.

## Timing
- **Reset values:** `push`, `pe`, `fe`, `bi` and `busy` = 0; `dout` = 0; state IDLE; counters 0; synchroniser flops 1.
- **Reset mid-frame:** aborts immediately. No `push` is produced and the next frame is received normally.
- **Pin-to-detection latency:** SYNC_STAGES `clk` cycles plus the wait for the next `baud_pulse`.
- **`push` timing:**
  - `push` rises 1 `clk` after the `baud_pulse` at which the STOP decision is made.
  - That pulse lies (1 + N + pen)·OSR + D baud_pulses after the detection pulse (tick 0).
  - Example, OSR = 16, 8N1: D = 8 gives 152 pulses; D = 9 gives 153.
- **`busy`:** rises 1 `clk` after the detection pulse and falls 1 `clk` after the leaving pulse.
- **`baud_pulse` rules:** `baud_pulse` is ignored by the state machine while low. If it is held high every cycle, the block must still be correct.

## Configuration
- Macro: **`UART_RX_MAJORITY_EN`**.
- **Defined:** each bit value is the 2-of-3 majority of `rx_s` at ticks S-1, S and S+1, and D = S+1. A single-tick glitch at S does not corrupt a bit or abort a valid start.
- **Undefined:** a single sample of `rx_s` at tick S is used, and D = S. No vote registers are built.

## Test plan
- **8N1, OSR = 16:** send 0xA5.
  - `push` fires once, 152 pulses after detection (153 with the macro).
  - `dout` = 0xA5; `pe`, `fe` and `bi` = 0.
- **7-bit even parity:** `wls` = 10, `pen` = 1, `eps` = 1. Send 0x35 with the correct parity bit 0, then again with parity bit 1.
  - First frame: `pe` = 0. Second frame: `pe` = 1. `dout` = 0x35 both times.
- **False start:** 3-tick low pulse on `rx`. Expect no `push` and `busy` back to 0 by tick D+1.
- **Break:** hold `rx` low for 3 frame times, then release.
  - Exactly one `push`, with `dout` = 0, `fe` = 1, `bi` = 1.
  - State stays BRK_WAIT until `rx` is high.
  - A following 0x55 is received cleanly.
- **Framing error and reset:**
  - Stop bit forced 0 on 0x0F: `fe` = 1, `bi` = 0.
  - Assert `rst` mid-DATA: no `push`, all outputs 0, and the next 0x3C is received correctly.
- **Glitch (macro defined):** single-tick inversion at tick S of data bit 3 of 0x00. Expect `dout` = 0x00.

Source files
------------

// File: rtl/uart_rx_os_if.sv
// uart_rx_os_if: signal bundle between the baud generator/line side and the
// oversampling UART receiver, plus the RX FIFO side of the receiver.
// The receiver uses the slave modport. The driver of the line and
// configuration, or the bench, uses the master modport.
//
// Handshake: push is a one-cycle valid strobe with no ready. dout/pe/fe/bi
// are valid in the push cycle and hold until the next push. The consumer
// (RX FIFO) must accept in that cycle. There is no back-pressure path.
// state is a debug view of the receiver FSM.
interface uart_rx_os_if;
    logic       baud_pulse;
    logic       rx;
    logic       pen;
    logic       eps;
    logic       sticky_parity;
    logic [1:0] wls;
    logic       push;
    logic [7:0] dout;
    logic       pe;
    logic       fe;
    logic       bi;
    logic       busy;
    logic [2:0] state;

    modport master (
        output baud_pulse, rx, pen, eps, sticky_parity, wls,
        input  push, dout, pe, fe, bi, busy, state
    );

    modport slave (
        input  baud_pulse, rx, pen, eps, sticky_parity, wls,
        output push, dout, pe, fe, bi, busy, state
    );
endinterface

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver (5-8 data bits, optional parity,
// first stop bit checked, break detection with wait for line release).
// Optional feature macro: UART_RX_MAJORITY_EN selects 2-of-3 majority voting
// around the mid-bit point (decision one tick later). When the macro is
// undefined, a single mid-bit sample is used.
module uart_rx_os #(
    parameter int OSR         = 16,
    parameter int SYNC_STAGES = 2
) (
    input logic        clk,
    input logic        rst,
    uart_rx_os_if.slave bus
);
    localparam int TW = $clog2(OSR);
    localparam logic [TW-1:0] T_S    = TW'(OSR / 2);
    localparam logic [TW-1:0] T_LAST = TW'(OSR - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [TW-1:0] T_D    = TW'(OSR / 2 + 1);
`else
    localparam logic [TW-1:0] T_D    = TW'(OSR / 2);
`endif

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_START    = 3'd1;
    localparam logic [2:0] ST_DATA     = 3'd2;
    localparam logic [2:0] ST_PARITY   = 3'd3;
    localparam logic [2:0] ST_STOP     = 3'd4;
    localparam logic [2:0] ST_BRK_WAIT = 3'd5;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [2:0]             state;
    logic [TW-1:0]          tick;
    logic [2:0]             bit_cnt;
    logic [7:0]             shreg;
    logic [1:0]             wls_l;
    logic                   pen_l;
    logic                   eps_l;
    logic                   stick_l;
    logic                   par_bit;
    logic                   par_err;
    logic                   sample;
    logic                   at_d;
    logic                   at_last;
    logic                   push_q;
    logic [7:0]             dout_q;
    logic                   pe_q;
    logic                   fe_q;
    logic                   bi_q;

    // New bit enters at position N-1 so the finished word is right-justified.
    function automatic logic [7:0] shift_in(input logic [7:0] cur, input logic b,
                                            input logic [1:0] w);
        logic [7:0] nxt;
        nxt = cur >> 1;
        nxt[{1'b1, w}] = b;
        return nxt;
    endfunction

    // Metastability synchroniser; flops idle high like the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '1;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], bus.rx};
    end

    assign rx_s    = sync_q[SYNC_STAGES-1];
    assign at_d    = (tick == T_D);
    assign at_last = (tick == T_LAST);

`ifdef UART_RX_MAJORITY_EN
    logic vote_a;
    logic vote_b;

    // Capture the line at ticks S-1 and S; the vote completes at S+1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vote_a <= 1'b1;
            vote_b <= 1'b1;
        end else if (bus.baud_pulse) begin
            if (tick == T_S - 1'b1) vote_a <= rx_s;
            if (tick == T_S)        vote_b <= rx_s;
        end
    end

    assign sample = (vote_a & vote_b) | (vote_a & rx_s) | (vote_b & rx_s);
`else
    assign sample = rx_s;
`endif

    // Receiver FSM, tick counter, deserialiser and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            tick    <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            wls_l   <= '0;
            pen_l   <= 1'b0;
            eps_l   <= 1'b0;
            stick_l <= 1'b0;
            par_bit <= 1'b0;
            par_err <= 1'b0;
            push_q  <= 1'b0;
            dout_q  <= '0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            bi_q    <= 1'b0;
        end else begin
            push_q <= 1'b0;
            if (bus.baud_pulse) begin
                tick <= at_last ? '0 : tick + 1'b1;
                case (state)
                    ST_IDLE: begin
                        tick <= '0;
                        // The detecting pulse is tick 0, so the next one is tick 1.
                        if (!rx_s) begin
                            state <= ST_START;
                            tick  <= TW'(1);
                        end
                    end
                    ST_START: begin
                        if (at_d) begin
                            if (sample) begin
                                state <= ST_IDLE;
                                tick  <= '0;
                            end else begin
                                wls_l   <= bus.wls;
                                pen_l   <= bus.pen;
                                eps_l   <= bus.eps;
                                stick_l <= bus.sticky_parity;
                                shreg   <= '0;
                                par_bit <= 1'b0;
                                par_err <= 1'b0;
                            end
                        end
                        if (at_last) begin
                            state   <= ST_DATA;
                            bit_cnt <= {1'b1, wls_l};
                        end
                    end
                    ST_DATA: begin
                        if (at_d) shreg <= shift_in(shreg, sample, wls_l);
                        if (at_last) begin
                            if (bit_cnt == 3'd0) state <= pen_l ? ST_PARITY : ST_STOP;
                            else                 bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                    ST_PARITY: begin
                        if (at_d) begin
                            par_bit <= sample;
                            case ({stick_l, eps_l})
                                2'b00:   par_err <= ~(^shreg ^ sample);
                                2'b01:   par_err <= ^shreg ^ sample;
                                2'b10:   par_err <= ~sample;
                                default: par_err <= sample;
                            endcase
                        end
                        if (at_last) state <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (at_d) begin
                            push_q <= 1'b1;
                            dout_q <= shreg;
                            pe_q   <= pen_l & par_err;
                            fe_q   <= ~sample;
                            bi_q   <= ~sample & (shreg == 8'd0) & ~(pen_l & par_bit);
                            state  <= sample ? ST_IDLE : ST_BRK_WAIT;
                            tick   <= '0;
                        end
                    end
                    ST_BRK_WAIT: begin
                        if (rx_s) begin
                            state <= ST_IDLE;
                            tick  <= '0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        tick  <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.push  = push_q;
    assign bus.dout  = dout_q;
    assign bus.pe    = pe_q;
    assign bus.fe    = fe_q;
    assign bus.bi    = bi_q;
    assign bus.busy  = (state != ST_IDLE);
    assign bus.state = state;
endmodule
